dual_issue_hazard_unit: RTL and testbench

Generates the stall and flush controls for the REG-to-EX pipeline register of the dual-issue SPU core.
- Holds a per-register latency scoreboard for all 128 registers.
- Detects RAW/WAW hazards between the even/odd pair in the REG stage and in-flight results.
- Splits conflicting pairs and inserts bubbles.
- Flushes both pipes on a branch mispredict.
It sits beside the REG stage and drives stallEven/stallOdd/flushEven/flushOdd plus the front-end hold.

---
 rtl/spu_hazard_pkg.sv | 37 +++
 rtl/hazard_scoreboard.sv | 58 +++++
 rtl/dual_issue_hazard_unit.sv | 187 ++++++++++++++++++
 tb/tb_dual_issue_hazard_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_hazard_pkg.sv
// Shared types and constants for the dual-issue SPU hazard unit.
// FORWARDING_EN selects forwarded (L-1) or register-file (L-1+WB_DELAY) counts.
package spu_hazard_pkg;

  localparam int NUM_REGS     = 128;
  localparam int REG_W        = 7;
  localparam int LAT_W        = 3;
  localparam int WB_DELAY     = 2;
  localparam int FLUSH_CYCLES = 3;
  localparam int FCNT_W       = 2;

`ifdef FORWARDING_EN
  localparam int CNT_W = LAT_W;
`else
  // Room for 7 - 1 + WB_DELAY.
  localparam int CNT_W = LAT_W + 1;
`endif

  typedef enum logic [1:0] {
    PAIR  = 2'd0,
    SPLIT = 2'd1,
    FLUSH = 2'd2
  } hazard_state_t;

  function automatic logic [CNT_W-1:0] lat2cnt(
    input logic [LAT_W-1:0] lat
  );
    logic [CNT_W-1:0] l;
    l = (lat == '0) ? CNT_W'(1) : CNT_W'(lat);
`ifdef FORWARDING_EN
    return l - CNT_W'(1);
`else
    return l - CNT_W'(1) + CNT_W'(WB_DELAY);
`endif
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register issue-delay counters with two set ports and
// read lookups for six sources and two destinations.
module hazard_scoreboard
  import spu_hazard_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             freeze_i,
  input  logic             setE_i,
  input  logic [REG_W-1:0] setRegE_i,
  input  logic [CNT_W-1:0] setValE_i,
  input  logic             setO_i,
  input  logic [REG_W-1:0] setRegO_i,
  input  logic [CNT_W-1:0] setValO_i,
  input  logic [REG_W-1:0] src_i [6],
  output logic [5:0]       busy_o,
  input  logic [REG_W-1:0] rtE_i,
  input  logic [REG_W-1:0] rtO_i,
  output logic [CNT_W-1:0] rtCntE_o,
  output logic [CNT_W-1:0] rtCntO_o
);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!freeze_i && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      // A new writer overrides the ageing count.
      if (setE_i && setRegE_i == REG_W'(r))
        cnt_d[r] = setValE_i;
      if (setO_i && setRegO_i == REG_W'(r))
        cnt_d[r] = setValO_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < 6; i++)
      busy_o[i] = (cnt_q[src_i[i]] != '0);
  end

  assign rtCntE_o = cnt_q[rtE_i];
  assign rtCntO_o = cnt_q[rtO_i];

endmodule

// File: rtl/dual_issue_hazard_unit.sv
// REG->EX stall/flush control for the dual-issue SPU pair.
// FORWARDING_EN shortens scoreboard counts to forwarded latency.
module dual_issue_hazard_unit
  import spu_hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             validEven,
  input  logic             validOdd,
  input  logic             regWriteEnable_E,
  input  logic             regWriteEnable_O,
  input  logic [REG_W-1:0] readRegisterRA_E,
  input  logic [REG_W-1:0] readRegisterRB_E,
  input  logic [REG_W-1:0] readRegisterRC_E,
  input  logic [REG_W-1:0] readRegisterRT_E,
  input  logic [REG_W-1:0] readRegisterRA_O,
  input  logic [REG_W-1:0] readRegisterRB_O,
  input  logic [REG_W-1:0] readRegisterRC_O,
  input  logic [REG_W-1:0] readRegisterRT_O,
  input  logic             useRA_E,
  input  logic             useRB_E,
  input  logic             useRC_E,
  input  logic             useRA_O,
  input  logic             useRB_O,
  input  logic             useRC_O,
  input  logic [LAT_W-1:0] latency_E,
  input  logic [LAT_W-1:0] latency_O,
  input  logic             extStall,
  input  logic             mispredict,
  output logic             stallEven,
  output logic             stallOdd,
  output logic             stallFront,
  output logic             flushEven,
  output logic             flushOdd,
  output logic             splitActive
);

  hazard_state_t     state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [REG_W-1:0] src [6];
  logic [5:0]       busy;
  logic [CNT_W-1:0] rtCntE, rtCntO;
  logic             hazE, hazO, conflict;
  logic             issueE, issueO;

  assign src[0] = readRegisterRA_E;
  assign src[1] = readRegisterRB_E;
  assign src[2] = readRegisterRC_E;
  assign src[3] = readRegisterRA_O;
  assign src[4] = readRegisterRB_O;
  assign src[5] = readRegisterRC_O;

  hazard_scoreboard u_sb (
    .clk_i     (clk),
    .reset_i   (reset),
    .freeze_i  (extStall),
    .setE_i    (issueE & regWriteEnable_E),
    .setRegE_i (readRegisterRT_E),
    .setValE_i (lat2cnt(latency_E)),
    .setO_i    (issueO & regWriteEnable_O),
    .setRegO_i (readRegisterRT_O),
    .setValO_i (lat2cnt(latency_O)),
    .src_i     (src),
    .busy_o    (busy),
    .rtE_i     (readRegisterRT_E),
    .rtO_i     (readRegisterRT_O),
    .rtCntE_o  (rtCntE),
    .rtCntO_o  (rtCntO)
  );

  assign hazE = validEven & (
      (useRA_E & busy[0]) | (useRB_E & busy[1])
    | (useRC_E & busy[2])
    | (regWriteEnable_E & (rtCntE > lat2cnt(latency_E))));

  assign hazO = validOdd & (
      (useRA_O & busy[3]) | (useRB_O & busy[4])
    | (useRC_O & busy[5])
    | (regWriteEnable_O & (rtCntO > lat2cnt(latency_O))));

  assign conflict = validEven & validOdd & regWriteEnable_E & (
      (useRA_O & (readRegisterRA_O == readRegisterRT_E))
    | (useRB_O & (readRegisterRB_O == readRegisterRT_E))
    | (useRC_O & (readRegisterRC_O == readRegisterRT_E))
    | (regWriteEnable_O
       & (readRegisterRT_O == readRegisterRT_E)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PAIR;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (mispredict) begin
      state_d = FLUSH;
      fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
    end else if (!extStall) begin
      unique case (state_q)
        PAIR:
          if (!hazE && (conflict || hazO))
            state_d = SPLIT;
        SPLIT:
          if (!hazO)
            state_d = PAIR;
        FLUSH: begin
          if (fcnt_q != '0)
            fcnt_d = fcnt_q - FCNT_W'(1);
          if (fcnt_q <= FCNT_W'(1))
            state_d = PAIR;
        end
        default: state_d = PAIR;
      endcase
    end
  end

  always_comb begin
    stallEven  = 1'b0;
    stallOdd   = 1'b0;
    stallFront = 1'b0;
    flushEven  = 1'b0;
    flushOdd   = 1'b0;
    issueE     = 1'b0;
    issueO     = 1'b0;
    if (reset) begin
      stallFront = 1'b0;
    end else if (mispredict) begin
      flushEven  = 1'b1;
      flushOdd   = 1'b1;
      stallEven  = extStall;
      stallOdd   = extStall;
      stallFront = extStall;
    end else if (extStall) begin
      stallEven  = 1'b1;
      stallOdd   = 1'b1;
      stallFront = 1'b1;
      flushEven  = (state_q == FLUSH);
      flushOdd   = (state_q == FLUSH);
    end else begin
      unique case (state_q)
        PAIR: begin
          if (hazE) begin
            flushEven  = 1'b1;
            flushOdd   = 1'b1;
            stallFront = 1'b1;
          end else if (conflict || hazO) begin
            issueE     = validEven;
            flushEven  = !validEven;
            flushOdd   = 1'b1;
            stallFront = 1'b1;
          end else begin
            issueE    = validEven;
            issueO    = validOdd;
            flushEven = !validEven;
            flushOdd  = !validOdd;
          end
        end
        SPLIT: begin
          // Even half of this pair already left.
          flushEven = 1'b1;
          if (hazO) begin
            flushOdd   = 1'b1;
            stallFront = 1'b1;
          end else begin
            issueO   = validOdd;
            flushOdd = !validOdd;
          end
        end
        default: begin
          flushEven = 1'b1;
          flushOdd  = 1'b1;
        end
      endcase
    end
  end

  assign splitActive = !reset && !mispredict
                     && (state_q == SPLIT);

endmodule

// File: tb/tb_dual_issue_hazard_unit.sv
// Directed vectors and multi-cycle sequences for dual_issue_hazard_unit.
module tb_dual_issue_hazard_unit;

`ifdef FORWARDING_EN
  localparam int EXTRA = 0;
`else
  localparam int EXTRA = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       validEven, validOdd;
  logic       regWriteEnable_E, regWriteEnable_O;
  logic [6:0] rA_E, rB_E, rC_E, rT_E;
  logic [6:0] rA_O, rB_O, rC_O, rT_O;
  logic       useRA_E, useRB_E, useRC_E;
  logic       useRA_O, useRB_O, useRC_O;
  logic [2:0] latency_E, latency_O;
  logic       extStall, mispredict;
  logic       stallEven, stallOdd, stallFront;
  logic       flushEven, flushOdd, splitActive;

  int total = 0;
  int bad   = 0;

  dual_issue_hazard_unit dut (
    .clk              (clk),
    .reset            (reset),
    .validEven        (validEven),
    .validOdd         (validOdd),
    .regWriteEnable_E (regWriteEnable_E),
    .regWriteEnable_O (regWriteEnable_O),
    .readRegisterRA_E (rA_E),
    .readRegisterRB_E (rB_E),
    .readRegisterRC_E (rC_E),
    .readRegisterRT_E (rT_E),
    .readRegisterRA_O (rA_O),
    .readRegisterRB_O (rB_O),
    .readRegisterRC_O (rC_O),
    .readRegisterRT_O (rT_O),
    .useRA_E          (useRA_E),
    .useRB_E          (useRB_E),
    .useRC_E          (useRC_E),
    .useRA_O          (useRA_O),
    .useRB_O          (useRB_O),
    .useRC_O          (useRC_O),
    .latency_E        (latency_E),
    .latency_O        (latency_O),
    .extStall         (extStall),
    .mispredict       (mispredict),
    .stallEven        (stallEven),
    .stallOdd         (stallOdd),
    .stallFront       (stallFront),
    .flushEven        (flushEven),
    .flushOdd         (flushOdd),
    .splitActive      (splitActive)
  );

  typedef struct {
    logic       vE, vO, weE, weO;
    logic [6:0] rtE, rtO, raO, rcO;
    logic       uaO, ucO, ext, mp;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic idle();
    validEven = 0; validOdd = 0;
    regWriteEnable_E = 0; regWriteEnable_O = 0;
    rA_E = 0; rB_E = 0; rC_E = 0; rT_E = 0;
    rA_O = 0; rB_O = 0; rC_O = 0; rT_O = 0;
    useRA_E = 0; useRB_E = 0; useRC_E = 0;
    useRA_O = 0; useRB_O = 0; useRC_O = 0;
    latency_E = 3'd1; latency_O = 3'd1;
    extStall = 0; mispredict = 0;
  endtask

  task automatic setE(input logic v, input logic we,
                      input logic [6:0] rt, input logic [2:0] lat,
                      input logic [6:0] ra, input logic ua);
    validEven = v; regWriteEnable_E = we; rT_E = rt;
    latency_E = lat; rA_E = ra; useRA_E = ua;
  endtask

  task automatic setO(input logic v, input logic we,
                      input logic [6:0] rt, input logic [2:0] lat,
                      input logic [6:0] ra, input logic ua);
    validOdd = v; regWriteEnable_O = we; rT_O = rt;
    latency_O = lat; rA_O = ra; useRA_O = ua;
  endtask

  // exp = {stallEven,stallOdd,stallFront,flushEven,flushOdd,splitActive}
  task automatic step(input string nm, input logic [5:0] exp);
    logic [5:0] act;
    @(negedge clk);
    act = {stallEven, stallOdd, stallFront,
           flushEven, flushOdd, splitActive};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    tbl[0]  = '{1,1,1,1, 1,2,3,4,   1,1,0,0, 6'b000000};
    tbl[1]  = '{0,1,1,1, 1,2,3,4,   1,1,0,0, 6'b000100};
    tbl[2]  = '{0,0,1,1, 1,2,3,4,   1,1,0,0, 6'b000110};
    tbl[3]  = '{1,1,1,0, 10,11,10,4, 1,0,0,0, 6'b001010};
    tbl[4]  = '{1,1,1,0, 10,11,4,10, 0,1,0,0, 6'b001010};
    tbl[5]  = '{1,1,1,0, 10,11,10,10, 0,0,0,0, 6'b000000};
    tbl[6]  = '{1,1,1,1, 20,20,1,2,  0,0,0,0, 6'b001010};
    tbl[7]  = '{1,1,1,0, 20,20,1,2,  0,0,0,0, 6'b000000};
    tbl[8]  = '{1,1,1,0, 0,5,0,2,    1,0,0,0, 6'b001010};
    tbl[9]  = '{1,1,1,1, 1,2,3,4,    1,1,1,0, 6'b111000};
    tbl[10] = '{1,1,1,1, 1,2,3,4,    1,1,0,1, 6'b000110};
    tbl[11] = '{0,1,1,0, 10,11,10,4, 1,0,0,0, 6'b000100};

    idle();
    reset = 1;
    step("reset_state", 6'b000000);
    reset = 0;

    for (int i = 0; i < 12; i++) begin
      do_reset();
      validEven = tbl[i].vE; validOdd = tbl[i].vO;
      regWriteEnable_E = tbl[i].weE;
      regWriteEnable_O = tbl[i].weO;
      rT_E = tbl[i].rtE; rT_O = tbl[i].rtO;
      rA_O = tbl[i].raO; rC_O = tbl[i].rcO;
      useRA_O = tbl[i].uaO; useRC_O = tbl[i].ucO;
      extStall = tbl[i].ext; mispredict = tbl[i].mp;
      step($sformatf("vec%0d", i), tbl[i].exp);
    end

    // External RAW on r5, L=4
    do_reset();
    setE(1, 1, 5, 4, 0, 0);
    step("A_wr", 6'b000010);
    setE(1, 0, 9, 1, 5, 1);
    for (int i = 0; i < 3 + EXTRA; i++)
      step("A_wait", 6'b001110);
    step("A_issue", 6'b000010);

    // Intra-pair RAW on r10
    do_reset();
    setE(1, 1, 10, 1, 0, 0);
    setO(1, 1, 11, 1, 10, 1);
    step("B_split", 6'b001010);
    for (int i = 0; i < EXTRA; i++)
      step("B_wait", 6'b001111);
    step("B_odd", 6'b000101);
    setE(1, 1, 12, 1, 0, 0);
    setO(1, 1, 13, 1, 0, 0);
    step("B_pair", 6'b000000);

    // WAW on r20; odd count must survive
    do_reset();
    setE(1, 1, 20, 1, 0, 0);
    setO(1, 1, 20, 4, 0, 0);
    step("C_split", 6'b001010);
    step("C_odd", 6'b000101);
    idle();
    setE(1, 0, 0, 1, 20, 1);
    for (int i = 0; i < 3 + EXTRA; i++)
      step("C_wait", 6'b001110);
    step("C_use", 6'b000010);

    // extStall freezes cnt[r3]=2
    do_reset();
    setE(1, 1, 3, 3'(3 - EXTRA), 0, 0);
    step("D_wr", 6'b000010);
    setE(1, 0, 0, 1, 3, 1);
    extStall = 1;
    step("D_frz0", 6'b111000);
    step("D_frz1", 6'b111000);
    extStall = 0;
    step("D_wait0", 6'b001110);
    step("D_wait1", 6'b001110);
    step("D_use", 6'b000010);

    // Mispredict mid-SPLIT
    do_reset();
    setE(1, 1, 10, 1, 0, 0);
    setO(1, 1, 11, 1, 10, 1);
    step("E_split", 6'b001010);
    mispredict = 1;
    step("E_mp", 6'b000110);
    mispredict = 0;
    step("E_fl1", 6'b000110);
    step("E_fl2", 6'b000110);
    setE(1, 1, 12, 1, 0, 0);
    setO(1, 1, 13, 1, 0, 0);
    step("E_pair", 6'b000000);

    // Mispredict inside FLUSH reloads the counter
    do_reset();
    mispredict = 1;
    step("G_mp", 6'b000110);
    step("G_reload", 6'b000110);
    mispredict = 0;
    step("G_fl1", 6'b000110);
    step("G_fl2", 6'b000110);
    setE(1, 1, 12, 1, 0, 0);
    setO(1, 1, 13, 1, 0, 0);
    step("G_pair", 6'b000000);

    // Reset mid-FLUSH with r7 busy
    do_reset();
    setE(1, 1, 7, 7, 0, 0);
    step("F_wr", 6'b000010);
    idle();
    mispredict = 1;
    step("F_mp", 6'b000110);
    mispredict = 0;
    step("F_fl", 6'b000110);
    reset = 1;
    step("F_rst", 6'b000000);
    reset = 0;
    setE(1, 0, 0, 1, 7, 1);
    setO(1, 1, 8, 1, 7, 1);
    step("F_go", 6'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
